axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Two-master, one-slave AXI4 read-channel arbiter sharing the NPC memory read port.
- Master 0 is the icache line-refill engine, which issues a 64B line as 8 beats of 64 bits (arlen=7). Master 1 is the LSU/dcache, which issues single or burst reads.
- One outstanding transaction at a time; the grant is held for the whole burst.
- Round-robin fairness, plus a beat-count checker that flags slave rlast protocol violations.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, read data width
- LEN_W, 8, AXI arlen width
- RST_LAST, 1, reset value of the last-grant pointer; 1 makes master 0 win the first tie

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m0_arvalid  in  1  icache read request
- m0_arready  out  1  icache address accepted
- m0_araddr  in  ADDR_W  icache address
- m0_arlen  in  LEN_W  icache beats-1
- m0_rvalid  out  1  icache data valid
- m0_rready  in  1  icache data ready
- m0_rdata  out  DATA_W  icache data
- m0_rresp  out  2  icache response
- m0_rlast  out  1  icache last beat
- m1_*  same set as m0_*, for the LSU
- s_arvalid  out  1  memory address valid
- s_arready  in  1  memory address ready
- s_araddr  out  ADDR_W  memory address
- s_arlen  out  LEN_W  memory beats-1
- s_rvalid  in  1  memory data valid
- s_rready  out  1  memory data ready
- s_rdata  in  DATA_W  memory data
- s_rresp  in  2  memory response
- s_rlast  in  1  memory last beat
- err_rlast  out  1  sticky: slave rlast disagreed with the beat count

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset: state=IDLE, last_grant=RST_LAST, beat_cnt=0, err_rlast=0, and latched addr/len=0. All valid/ready outputs are 0 while in IDLE with no request.
- Reset mid-burst returns to IDLE immediately. Any stray slave beats after reset are ignored: s_rready=0 in IDLE.
- State IDLE:
  - If any mX_arvalid, the winner's mX_arready=1 combinationally in the same cycle.
  - Latch araddr/arlen, set grant=X, beat_cnt=0, go to AR.
  - Only one arready is ever high.
- Arbitration:
  - Single requester wins.
  - When both request, the master other than last_grant wins.
  - last_grant updates only at burst completion.
- State AR:
  - s_arvalid=1 with the latched addr/len.
  - On s_arready go to R.
  - Master arvalid and addr changes are ignored while in AR.
- State R:
  - s_rready = mgrant_rready.
  - mgrant_rvalid = s_rvalid, with rdata/rresp/rlast passed through combinationally.
  - The non-granted master sees rvalid=0 and its arready=0.
  - beat_cnt increments on each s_rvalid&s_rready handshake.
- Burst end:
  - On a handshake with s_rlast=1, go to IDLE and set last_grant=grant.
  - The new arbitration happens in the following IDLE cycle, so there is one bubble cycle between bursts.
- rlast check (on every handshake):
  - s_rlast=1 while beat_cnt≠len sets err_rlast.
  - s_rlast=0 while beat_cnt==len also sets err_rlast.
  - On that s_rlast=0 case the FSM forces a return to IDLE to avoid hanging, and the beat is still forwarded to the master with mX_rlast=1.
  - err_rlast stays set until rst.
- rresp is forwarded unmodified. Errors do not abort the burst.
- Latency:
  - Request at cycle 0 gives arready at cycle 0 and s_arvalid at cycle 1.
  - Data adds no register stage.
  - Minimum issue-to-issue spacing is len+4 cycles with a zero-wait slave.
- beat_cnt is LEN_W bits wide. arlen=255 is legal and wrap cannot occur before rlast.

Decomposition:
- Shared package npc_axi_pkg:
  - arb_state_e {IDLE, AR, R}
  - RESP_OKAY/EXOKAY/SLVERR/DECERR
  - ICACHE_LINE_BEATS=8
  - the ADDR_W/DATA_W defaults
- Sub-module rr_arb2:
  - inputs req[1:0], last_grant, en; outputs gnt[1:0] (one-hot) and gnt_id.
  - Purely combinational.
  - The pointer register stays in the top level.

Test Plan:
- Icache only, m0 araddr=0x8000_0040, arlen=7:
  - m0_arready is high in the request cycle.
  - s_araddr=0x8000_0040 and s_arlen=7 one cycle later.
  - 8 beats reach m0 with rlast on the 8th.
  - m1_rvalid stays 0 throughout.
- Both request in the same cycle after reset:
  - m0 is granted first (last_grant=1).
  - After m0's rlast, one bubble cycle, then m1 (arlen=0) is granted.
  - The next tie grants m0 again.
- LSU 1-beat read with m1_rready low for 3 cycles:
  - s_rready stays low for those 3 cycles.
  - rdata 0xDEAD_BEEF_0000_1234 is delivered when ready rises.
  - The FSM returns to IDLE.
- Slave asserts rlast on beat 3 of an arlen=7 burst:
  - err_rlast=1.
  - FSM returns to IDLE.
  - err_rlast remains 1 until rst.
- rst asserted in R after beat 4:
  - Next cycle: state IDLE, all arready/arvalid/rvalid=0, err_rlast=0.
  - A new m1 request is then served normally.
- Slave returns rresp=SLVERR on beat 2:
  - Forwarded to m0 unchanged.
  - The burst completes all 8 beats.

Source files
------------

// File: rtl/npc_axi_pkg.sv
// npc_axi_pkg
// Shared AXI read-path definitions for the NPC memory subsystem.
//   arb_state_e       : read-arbiter FSM states
//   RESP_*            : AXI rresp encodings
//   ICACHE_LINE_BEATS : beats per icache line refill (64B / 8B)
//   ADDR_W_DEF/DATA_W_DEF : default bus widths
package npc_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ICACHE_LINE_BEATS = 8;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   req[1:0]   : request vector
//   last_grant : id of the master that completed the most recent burst
//   en         : arbitration enable; no grant is produced when low
//   gnt[1:0]   : one-hot grant
//   gnt_id     : index of the granted master (valid when gnt != 0)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    if (en && (req != 2'b00)) begin
      // On a tie the master that did not go last wins; otherwise the lone requester.
      if (req == 2'b11) begin
        gnt_id = ~last_grant;
      end else begin
        gnt_id = req[1];
      end
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Two-master, one-slave AXI4 read-channel arbiter. One transaction in flight;
// the grant is held for the whole burst. Round-robin between masters, with a
// sticky checker for slave rlast disagreeing with the requested beat count.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   m0_* (icache), m1_* (LSU): AR channel in (arvalid/araddr/arlen, arready out)
//                              R channel out (rvalid/rdata/rresp/rlast, rready in)
//   s_*                      : slave-side AR and R channels
//   err_rlast                : sticky rlast protocol violation flag
module axi_rd_arbiter
  import npc_axi_pkg::*;
#(
  parameter int   ADDR_W   = ADDR_W_DEF,
  parameter int   DATA_W   = DATA_W_DEF,
  parameter int   LEN_W    = 8,
  parameter logic RST_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [LEN_W-1:0]  m0_arlen,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,

  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [LEN_W-1:0]  m1_arlen,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,

  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [LEN_W-1:0]  s_arlen,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,

  output logic              err_rlast
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;
  // Set for exactly the IDLE cycle following a burst, so each burst is
  // followed by one bubble before the next arbitration.
  logic              bubble_q, bubble_d;

  logic [1:0] arb_gnt;
  logic       arb_gnt_id;
  logic       arb_en;
  logic       rready_sel;
  logic       hs;
  logic       last_exp;
  logic       rlast_fwd;

  assign arb_en     = (state_q == IDLE) && !bubble_q;
  assign rready_sel = grant_q ? m1_rready : m0_rready;
  assign hs         = (state_q == R) && s_rvalid && rready_sel;
  assign last_exp   = (beat_cnt_q == len_q);
  // A missing slave rlast on the final expected beat is still presented to
  // the master as the last beat so it never waits for data that won't come.
  assign rlast_fwd  = s_rlast || last_exp;

  rr_arb2 u_arb (
    .req        ({m1_arvalid, m0_arvalid}),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .gnt        (arb_gnt),
    .gnt_id     (arb_gnt_id)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    addr_d       = addr_q;
    len_d        = len_q;
    err_d        = err_q;
    bubble_d     = 1'b0;

    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rlast   = 1'b0;
    m1_rlast   = 1'b0;
    m0_rdata   = s_rdata;
    m1_rdata   = s_rdata;
    m0_rresp   = s_rresp;
    m1_rresp   = s_rresp;
    s_arvalid  = 1'b0;
    s_araddr   = addr_q;
    s_arlen    = len_q;
    s_rready   = 1'b0;

    case (state_q)
      IDLE: begin
        m0_arready = arb_gnt[0];
        m1_arready = arb_gnt[1];
        if (arb_gnt != 2'b00) begin
          grant_d    = arb_gnt_id;
          addr_d     = arb_gnt_id ? m1_araddr : m0_araddr;
          len_d      = arb_gnt_id ? m1_arlen  : m0_arlen;
          beat_cnt_d = '0;
          state_d    = AR;
        end
      end

      AR: begin
        s_arvalid = 1'b1;
        if (s_arready) begin
          state_d = R;
        end
      end

      R: begin
        s_rready = rready_sel;
        if (grant_q) begin
          m1_rvalid = s_rvalid;
          m1_rlast  = rlast_fwd;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rlast  = rlast_fwd;
        end
        if (hs) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (s_rlast != last_exp) begin
            err_d = 1'b1;
          end
          // Either an early slave rlast or the expected final beat ends the burst.
          if (rlast_fwd) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
            bubble_d     = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= RST_LAST;
      beat_cnt_q   <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      bubble_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      err_q        <= err_d;
      bubble_q     <= bubble_d;
    end
  end

  assign err_rlast = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
// Self-checking bench: a per-cycle vector table for the tie/round-robin
// sequence, then hand-written sequences for bursts, backpressure, rresp
// forwarding, rlast errors and mid-burst reset.
module tb_axi_rd_arbiter;
  import npc_axi_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [ADDR_W-1:0] m0_araddr;
  logic [LEN_W-1:0]  m0_arlen;
  logic [DATA_W-1:0] m0_rdata;
  logic [1:0]        m0_rresp;
  logic              m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [ADDR_W-1:0] m1_araddr;
  logic [LEN_W-1:0]  m1_arlen;
  logic [DATA_W-1:0] m1_rdata;
  logic [1:0]        m1_rresp;
  logic              s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [ADDR_W-1:0] s_araddr;
  logic [LEN_W-1:0]  s_arlen;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              err_rlast;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RST_LAST(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .err_rlast(err_rlast)
  );

  // in_bits : {m0_arvalid, m1_arvalid, s_arready, s_rvalid, s_rlast, m0_rready, m1_rready}
  // exp_bits: {m0_arready, m1_arready, s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast}
  typedef struct {
    logic [6:0] in_bits;
    logic [7:0] exp_bits;
    string      name;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_pass++;
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_arvalid = 0; m0_araddr = '0; m0_arlen = '0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_arlen = '0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = RESP_OKAY; s_rlast = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Issue a request from one master into an idle, bubble-free arbiter and
  // walk it through the AR phase with a zero-wait slave.
  task automatic issue(input logic who, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    if (who) begin
      m1_arvalid = 1; m1_araddr = addr; m1_arlen = len;
    end else begin
      m0_arvalid = 1; m0_araddr = addr; m0_arlen = len;
    end
    #1;
    chk(who ? "issue_m1_arready" : "issue_m0_arready", who ? m1_arready : m0_arready, 1);
    chk("issue_other_arready", who ? m0_arready : m1_arready, 0);
    tick();
    m0_arvalid = 0; m1_arvalid = 0;
    s_arready = 1;
    #1;
    chk("issue_s_arvalid", s_arvalid, 1);
    chk("issue_s_araddr", s_araddr, addr);
    chk("issue_s_arlen", s_arlen, len);
    tick();
    s_arready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{7'b1100011, 8'b10000000, "tie_grants_m0"};
    tbl[1]  = '{7'b0110011, 8'b00100000, "ar_m0"};
    tbl[2]  = '{7'b0101011, 8'b00011000, "m0_beat0"};
    tbl[3]  = '{7'b0100011, 8'b00010000, "m0_stall"};
    tbl[4]  = '{7'b0101011, 8'b00011000, "m0_beat1"};
    tbl[5]  = '{7'b0101011, 8'b00011000, "m0_beat2"};
    tbl[6]  = '{7'b0101011, 8'b00011000, "m0_beat3"};
    tbl[7]  = '{7'b0101011, 8'b00011000, "m0_beat4"};
    tbl[8]  = '{7'b0101011, 8'b00011000, "m0_beat5"};
    tbl[9]  = '{7'b0101011, 8'b00011000, "m0_beat6"};
    tbl[10] = '{7'b0101111, 8'b00011010, "m0_beat7_last"};
    tbl[11] = '{7'b0100011, 8'b00000000, "bubble_after_m0"};
    tbl[12] = '{7'b0100011, 8'b01000000, "m1_granted"};
    tbl[13] = '{7'b0010011, 8'b00100000, "ar_m1"};
    tbl[14] = '{7'b0001111, 8'b00010101, "m1_single_beat"};
    tbl[15] = '{7'b1100011, 8'b00000000, "bubble_after_m1"};
    tbl[16] = '{7'b1100011, 8'b10000000, "tie_grants_m0_again"};

    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("rst_outputs", {m0_arready, m1_arready, s_arvalid, s_rready, m0_rvalid, m1_rvalid}, 6'b0);
    chk("rst_err", err_rlast, 0);

    // ---------------- table: tie / round-robin ----------------
    m0_araddr = 32'h8000_0040; m0_arlen = 8'd7;
    m1_araddr = 32'h0000_1000; m1_arlen = 8'd0;
    for (int i = 0; i < NVEC; i++) begin
      {m0_arvalid, m1_arvalid, s_arready, s_rvalid, s_rlast, m0_rready, m1_rready} = tbl[i].in_bits;
      #1;
      chk($sformatf("vec%0d_%s", i, tbl[i].name),
          {m0_arready, m1_arready, s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast},
          tbl[i].exp_bits);
      tick();
    end

    // ---------------- A: icache line refill ----------------
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h8000_0040; m0_arlen = 8'd7;
    #1;
    chk("A_m0_arready", m0_arready, 1);
    chk("A_m1_arready", m1_arready, 0);
    tick();
    // Master changes after acceptance must not disturb the latched request.
    m0_arvalid = 1; m0_araddr = 32'hFFFF_0000; m0_arlen = 8'd3;
    #1;
    chk("A_s_arvalid", s_arvalid, 1);
    chk("A_s_araddr", s_araddr, 32'h8000_0040);
    chk("A_s_arlen", s_arlen, 7);
    chk("A_m0_arready_in_ar", m0_arready, 0);
    s_arready = 1;
    tick();
    m0_arvalid = 0; s_arready = 0; m0_rready = 1;
    for (int i = 0; i < ICACHE_LINE_BEATS; i++) begin
      s_rvalid = 1; s_rdata = 64'h0000_A000 + 64'(i); s_rlast = (i == 7);
      #1;
      chk($sformatf("A_beat%0d_rvalid", i), m0_rvalid, 1);
      chk($sformatf("A_beat%0d_rdata", i), m0_rdata, 64'h0000_A000 + 64'(i));
      chk($sformatf("A_beat%0d_rlast", i), m0_rlast, (i == 7));
      chk($sformatf("A_beat%0d_m1_rvalid", i), m1_rvalid, 0);
      tick();
    end
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("A_idle_s_rready", s_rready, 0);
    chk("A_err", err_rlast, 0);
    tick();

    // ---------------- B: LSU single beat with backpressure ----------------
    issue(1'b1, 32'h0000_2000, 8'd0);
    s_rvalid = 1; s_rdata = 64'hDEAD_BEEF_0000_1234; s_rlast = 1; m1_rready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("B_wait%0d_s_rready", i), s_rready, 0);
      chk($sformatf("B_wait%0d_m1_rvalid", i), m1_rvalid, 1);
      tick();
    end
    m1_rready = 1;
    #1;
    chk("B_s_rready", s_rready, 1);
    chk("B_m1_rdata", m1_rdata, 64'hDEAD_BEEF_0000_1234);
    chk("B_m1_rlast", m1_rlast, 1);
    tick();
    s_rvalid = 0; s_rlast = 0; m1_rready = 0;
    #1;
    chk("B_idle", {s_rready, s_arvalid, m1_rvalid}, 3'b000);
    tick();

    // ---------------- C: SLVERR forwarded on beat 2 ----------------
    issue(1'b0, 32'h8000_0080, 8'd7);
    m0_rready = 1;
    for (int i = 0; i < 8; i++) begin
      s_rvalid = 1; s_rresp = (i == 2) ? RESP_SLVERR : RESP_OKAY; s_rlast = (i == 7);
      #1;
      chk($sformatf("C_beat%0d_rresp", i), m0_rresp, (i == 2) ? RESP_SLVERR : RESP_OKAY);
      chk($sformatf("C_beat%0d_rlast", i), m0_rlast, (i == 7));
      tick();
    end
    s_rvalid = 0; s_rlast = 0; s_rresp = RESP_OKAY;
    #1;
    chk("C_err", err_rlast, 0);
    chk("C_idle_s_rready", s_rready, 0);
    tick();

    // ---------------- D: early slave rlast ----------------
    issue(1'b0, 32'h8000_00C0, 8'd7);
    for (int i = 0; i < 3; i++) begin
      s_rvalid = 1; s_rlast = (i == 2);
      #1;
      chk($sformatf("D_beat%0d_rlast", i), m0_rlast, (i == 2));
      tick();
    end
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("D_err_set", err_rlast, 1);
    chk("D_idle_s_rready", s_rready, 0);
    tick();
    issue(1'b1, 32'h0000_2100, 8'd0);
    m1_rready = 1; s_rvalid = 1; s_rlast = 1;
    #1;
    chk("D_next_m1_rvalid", m1_rvalid, 1);
    tick();
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("D_err_sticky", err_rlast, 1);
    tick();

    // ---------------- E: reset in R after beat 4 ----------------
    issue(1'b1, 32'h0000_3000, 8'd7);
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 1; s_rlast = 0;
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("E_arready", {m0_arready, m1_arready}, 2'b00);
    chk("E_s_arvalid", s_arvalid, 0);
    chk("E_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    chk("E_stray_s_rready", s_rready, 0);
    chk("E_err_cleared", err_rlast, 0);
    s_rvalid = 0;
    issue(1'b1, 32'h0000_4000, 8'd1);
    for (int i = 0; i < 2; i++) begin
      s_rvalid = 1; s_rlast = (i == 1);
      #1;
      chk($sformatf("E_beat%0d_m1_rlast", i), m1_rlast, (i == 1));
      tick();
    end
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("E_err_after", err_rlast, 0);
    tick();

    // ---------------- F: slave misses rlast ----------------
    issue(1'b0, 32'h0000_5000, 8'd1);
    m0_rready = 1;
    s_rvalid = 1; s_rlast = 0;
    #1;
    chk("F_beat0_rlast", m0_rlast, 0);
    tick();
    #1;
    chk("F_beat1_forced_rlast", m0_rlast, 1);
    tick();
    s_rvalid = 0;
    #1;
    chk("F_err_set", err_rlast, 1);
    chk("F_idle_s_rready", s_rready, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
